// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the sargantana icache and its IFILL responder.
// Holds the icache fill request/response payloads and the responder state encoding.
package sargantana_icache_pkg;

    localparam int unsigned PADDR_SIZE = 26;
    localparam int unsigned WAY_WIDHT  = 128;
    localparam int unsigned WAY_IDX_W  = 2;
    localparam int unsigned BEAT_W     = 2;
    localparam int unsigned MEM_LEN_W  = 8;

    localparam int unsigned IFILL_MEM_DATA_W     = 64;
    localparam int unsigned IFILL_WORDS_PER_BEAT = WAY_WIDHT / IFILL_MEM_DATA_W;

    // Fill request from the icache controller
    typedef struct packed {
        logic                  valid;
        logic [WAY_IDX_W-1:0]  way;
        logic [PADDR_SIZE-1:0] paddr;
    } ifill_req_o_t;

    // Fill response back to the icache controller
    typedef struct packed {
        logic                 valid;
        logic                 ack;
        logic [WAY_WIDHT-1:0] data;
        logic [BEAT_W-1:0]    beat;
    } ifill_resp_i_t;

    typedef enum logic [1:0] {
        IFR_IDLE,
        IFR_MEM_REQ,
        IFR_COLLECT,
        IFR_SEND
    } ifill_rsp_state_t;

endpackage

// File: rtl/sargantana_ifill_responder_if.sv
// Bundle of the IFILL responder handshake signals: icache request/response and
// the 64-bit memory read port.
//   slave  : the responder (consumes requests and memory data)
//   master : the icache + memory side (drives requests and memory data)
interface sargantana_ifill_responder_if
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned MEM_DATA_W = IFILL_MEM_DATA_W
);
    ifill_req_o_t            ifill_req_i;
    ifill_resp_i_t           ifill_resp_o;
    logic                    mem_req_valid_o;
    logic                    mem_req_ready_i;
    logic [PADDR_SIZE+3:0]   mem_req_addr_o;
    logic [MEM_LEN_W-1:0]    mem_req_len_o;
    logic                    mem_resp_valid_i;
    logic [MEM_DATA_W-1:0]   mem_resp_data_i;
    logic                    busy_o;

    modport slave (
        input  ifill_req_i,
        input  mem_req_ready_i,
        input  mem_resp_valid_i,
        input  mem_resp_data_i,
        output ifill_resp_o,
        output mem_req_valid_o,
        output mem_req_addr_o,
        output mem_req_len_o,
        output busy_o
    );

    modport master (
        output ifill_req_i,
        output mem_req_ready_i,
        output mem_resp_valid_i,
        output mem_resp_data_i,
        input  ifill_resp_o,
        input  mem_req_valid_o,
        input  mem_req_addr_o,
        input  mem_req_len_o,
        input  busy_o
    );

endinterface

// File: rtl/sargantana_ifill_packer.sv
// Packs consecutive memory words into one WAY_WIDHT beat, lowest word first.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        restart packing at word 0 (buffer contents kept)
//   word_valid_i   a memory word is present this cycle
//   word_data_i    the memory word
//   beat_c         buffer with the current word already merged in its slot
//   beat_done_c    the current word completes a beat
module sargantana_ifill_packer
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned MEM_DATA_W = IFILL_MEM_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  word_valid_i,
    input  logic [MEM_DATA_W-1:0] word_data_i,
    output logic [WAY_WIDHT-1:0]  beat_c,
    output logic                  beat_done_c
);

    localparam int unsigned WORDS = WAY_WIDHT / MEM_DATA_W;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    logic [WORDS-1:0][MEM_DATA_W-1:0] buf_q;
    logic [WORDS-1:0][MEM_DATA_W-1:0] merged;
    logic [CNT_W-1:0]                 word_cnt_q;

    // Merge the incoming word so a completed beat is visible in the same cycle
    always_comb begin
        merged             = buf_q;
        merged[word_cnt_q] = word_data_i;
    end

    assign beat_c      = merged;
    assign beat_done_c = word_valid_i && (word_cnt_q == LAST_WORD);

    // Slot write and wrapping word counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q      <= '0;
            word_cnt_q <= '0;
        end else if (clear_i) begin
            word_cnt_q <= '0;
        end else if (word_valid_i) begin
            buf_q      <= merged;
            word_cnt_q <= (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sargantana_ifill_responder.sv
// Memory-side end of the icache IFILL protocol. Acknowledges a fill request,
// issues one line read on the memory port, packs returned words into beats and
// returns each beat with its index.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset (abandons any transfer in flight)
//   bus    slave side of sargantana_ifill_responder_if:
//            ifill_req_i / ifill_resp_o         icache request and response
//            mem_req_valid_o/ready_i/addr_o/len_o  line read request
//            mem_resp_valid_i / mem_resp_data_i  returned words, ascending address
//            busy_o                              a request is in flight
module sargantana_ifill_responder
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned LINE_BEATS = 1,
    parameter int unsigned MEM_DATA_W = IFILL_MEM_DATA_W
) (
    input logic                         clk_i,
    input logic                         rst_i,
    sargantana_ifill_responder_if.slave bus
);

    localparam int unsigned WORDS_PER_BEAT = WAY_WIDHT / MEM_DATA_W;
    localparam int unsigned LINE_WORDS     = LINE_BEATS * WORDS_PER_BEAT;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    if ((WAY_WIDHT % MEM_DATA_W) != 0 || LINE_BEATS < 1 || LINE_BEATS > 4) begin : g_bad_cfg
        $error("sargantana_ifill_responder: unsupported LINE_BEATS/MEM_DATA_W");
    end

    ifill_rsp_state_t        state_q;
    logic [WAY_IDX_W-1:0]    way_q;
    logic [BEAT_W-1:0]       beat_cnt_q;
    logic                    ack_q;
    logic                    resp_valid_q;
    logic [WAY_WIDHT-1:0]    resp_data_q;
    logic [BEAT_W-1:0]       resp_beat_q;
    logic                    mem_req_valid_q;
    logic [PADDR_SIZE+3:0]   mem_req_addr_q;
    logic                    busy_q;

    logic                    word_valid;
    logic [WAY_WIDHT-1:0]    beat_c;
    logic                    beat_done_c;

    // Words outside COLLECT are dropped; the packer restarts whenever idle
    assign word_valid = bus.mem_resp_valid_i && (state_q == IFR_COLLECT);

    sargantana_ifill_packer #(
        .MEM_DATA_W (MEM_DATA_W)
    ) u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (state_q == IFR_IDLE),
        .word_valid_i (word_valid),
        .word_data_i  (bus.mem_resp_data_i),
        .beat_c       (beat_c),
        .beat_done_c  (beat_done_c)
    );

    // Control FSM with registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IFR_IDLE;
            way_q           <= '0;
            beat_cnt_q      <= '0;
            ack_q           <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_beat_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            busy_q          <= 1'b0;
        end else begin
            case (state_q)
                IFR_IDLE: begin
                    if (bus.ifill_req_i.valid) begin
                        way_q          <= bus.ifill_req_i.way;
                        mem_req_addr_q <= {bus.ifill_req_i.paddr, 4'b0000};
                        ack_q          <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= IFR_MEM_REQ;
                    end
                end
                // First cycle here is the ack cycle; the read request follows it
                IFR_MEM_REQ: begin
                    ack_q <= 1'b0;
                    if (mem_req_valid_q && bus.mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= IFR_COLLECT;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                    end
                end
                IFR_COLLECT: begin
                    if (beat_done_c) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= beat_c;
                        resp_beat_q  <= beat_cnt_q;
                        state_q      <= IFR_SEND;
                    end
                end
                IFR_SEND: begin
                    resp_valid_q <= 1'b0;
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= IFR_IDLE;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                        state_q    <= IFR_COLLECT;
                    end
                end
                default: begin
                    state_q <= IFR_IDLE;
                end
            endcase
        end
    end

    assign bus.ifill_resp_o.valid = resp_valid_q;
    assign bus.ifill_resp_o.ack   = ack_q;
    assign bus.ifill_resp_o.data  = resp_data_q;
    assign bus.ifill_resp_o.beat  = resp_beat_q;
    assign bus.mem_req_valid_o    = mem_req_valid_q;
    assign bus.mem_req_addr_o     = mem_req_addr_q;
    assign bus.mem_req_len_o      = MEM_LEN_W'(LINE_WORDS - 1);
    assign bus.busy_o             = busy_q;

    // Memory must hold off while a beat is being returned
    a_no_word_in_send: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.mem_resp_valid_i && state_q == IFR_SEND))
        else $error("memory word presented during SEND");

    // Words outside a line read are dropped
    a_no_word_outside_read: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.mem_resp_valid_i && (state_q == IFR_IDLE || state_q == IFR_MEM_REQ)))
        else $error("memory word presented with no read outstanding");

    a_ack_valid_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(ack_q && resp_valid_q))
        else $error("ack and valid high together");

    // The latched way is only for visibility but must not drift mid-transfer
    a_way_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != IFR_IDLE) && ($past(state_q) != IFR_IDLE) |-> $stable(way_q))
        else $error("latched way changed during transfer");

endmodule

// File: tb/tb_sargantana_ifill_responder.sv
// Directed bench for sargantana_ifill_responder: a one-beat instance driven from
// a vector table plus hand sequences, and a four-beat instance for multi-beat fills.
module tb_sargantana_ifill_responder;
    import sargantana_icache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sargantana_ifill_responder_if bus1 ();
    sargantana_ifill_responder_if bus4 ();

    sargantana_ifill_responder #(.LINE_BEATS(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
    sargantana_ifill_responder #(.LINE_BEATS(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));

    // ---------------- memory models ----------------
    logic [63:0] wq1[$];
    logic [63:0] wq4[$];
    int rd1 = 0, vcnt1 = 0, wait1 = 0, nsent1 = 0;
    int rd4 = 0, vcnt4 = 0, wait4 = 0, nsent4 = 0;
    bit col1 = 0, col4 = 0;

    // A beat-completing word is followed by at least one idle cycle (the SEND cycle)
    always @(negedge clk) begin
        bus1.mem_req_ready_i  = 1'b0;
        bus1.mem_resp_valid_i = 1'b0;
        bus1.mem_resp_data_i  = '0;
        if (rst) begin
            col1 = 0; vcnt1 = 0; wq1.delete();
        end else begin
            if (col1 && wq1.size() > 0) begin
                if (wait1 > 0) wait1--;
                else begin
                    bus1.mem_resp_valid_i = 1'b1;
                    bus1.mem_resp_data_i  = wq1.pop_front();
                    nsent1++;
                    wait1 = (nsent1 % 2 == 0) ? 1 : 0;
                    if (nsent1 == 2) col1 = 0;
                end
            end
            if (bus1.mem_req_valid_o) begin
                vcnt1++;
                if (vcnt1 > rd1) begin
                    bus1.mem_req_ready_i = 1'b1;
                    col1 = 1; nsent1 = 0; wait1 = 0; vcnt1 = 0;
                end
            end else vcnt1 = 0;
        end
    end

    always @(negedge clk) begin
        bus4.mem_req_ready_i  = 1'b0;
        bus4.mem_resp_valid_i = 1'b0;
        bus4.mem_resp_data_i  = '0;
        if (rst) begin
            col4 = 0; vcnt4 = 0; wq4.delete();
        end else begin
            if (col4 && wq4.size() > 0) begin
                if (wait4 > 0) wait4--;
                else begin
                    bus4.mem_resp_valid_i = 1'b1;
                    bus4.mem_resp_data_i  = wq4.pop_front();
                    nsent4++;
                    wait4 = int'($urandom_range(0, 3)) + ((nsent4 % 2 == 0) ? 1 : 0);
                    if (nsent4 == 8) col4 = 0;
                end
            end
            if (bus4.mem_req_valid_o) begin
                vcnt4++;
                if (vcnt4 > rd4) begin
                    bus4.mem_req_ready_i = 1'b1;
                    col4 = 1; nsent4 = 0; wait4 = 0; vcnt4 = 0;
                end
            end else vcnt4 = 0;
        end
    end

    // ---------------- monitors ----------------
    int ack_cyc1[$], rsp_cyc1[$], ack_cyc4[$], rsp_cyc4[$];
    logic [127:0] rsp_dat1[$], rsp_dat4[$];
    int rsp_beat1[$], rsp_beat4[$];
    int ovl1 = 0, ovl4 = 0, vcyc1 = 0, unstable1 = 0;
    logic [29:0] addr_seen1 = '0, prev_addr1 = '0, addr_seen4 = '0;
    logic prev_v1 = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.ifill_resp_o.ack) ack_cyc1.push_back(cyc);
            if (bus1.ifill_resp_o.valid) begin
                rsp_cyc1.push_back(cyc);
                rsp_dat1.push_back(bus1.ifill_resp_o.data);
                rsp_beat1.push_back(int'(bus1.ifill_resp_o.beat));
            end
            if (bus1.ifill_resp_o.ack && bus1.ifill_resp_o.valid) ovl1++;
            if (bus1.mem_req_valid_o) begin
                vcyc1++;
                if (prev_v1 && bus1.mem_req_addr_o != prev_addr1) unstable1++;
                addr_seen1 = bus1.mem_req_addr_o;
            end
            prev_v1    = bus1.mem_req_valid_o;
            prev_addr1 = bus1.mem_req_addr_o;

            if (bus4.ifill_resp_o.ack) ack_cyc4.push_back(cyc);
            if (bus4.ifill_resp_o.valid) begin
                rsp_cyc4.push_back(cyc);
                rsp_dat4.push_back(bus4.ifill_resp_o.data);
                rsp_beat4.push_back(int'(bus4.ifill_resp_o.beat));
            end
            if (bus4.ifill_resp_o.ack && bus4.ifill_resp_o.valid) ovl4++;
            if (bus4.mem_req_valid_o) addr_seen4 = bus4.mem_req_addr_o;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [127:0] dget(input logic [127:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 128'hDEAD;
    endfunction

    // Drive point: 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon1();
        ack_cyc1.delete(); rsp_cyc1.delete(); rsp_dat1.delete(); rsp_beat1.delete();
        vcyc1 = 0; unstable1 = 0;
    endtask

    typedef struct {
        logic [25:0]  paddr;
        logic [1:0]   way;
        logic [63:0]  w0;
        logic [63:0]  w1;
        int           rdy;       // cycles mem_req_ready_i stays low
        int           hold;      // extra cycles the icache keeps valid after seeing ack
        logic [29:0]  exp_addr;
        logic [127:0] exp_data;
        int           exp_lat;   // request cycle to response-valid cycle
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v, input string tag);
        int t0;
        int hold_left;
        int k;
        clear_mon1();
        rd1 = v.rdy;
        wq1.push_back(v.w0);
        wq1.push_back(v.w1);
        tick();
        t0 = cyc;
        bus1.ifill_req_i = '{valid: 1'b1, way: v.way, paddr: v.paddr};
        hold_left = v.hold;
        k = 0;
        while (rsp_cyc1.size() == 0 && k < 60) begin
            tick();
            k++;
            if (ack_cyc1.size() > 0) begin
                if (hold_left == 0) bus1.ifill_req_i.valid = 1'b0;
                else hold_left--;
            end
        end
        bus1.ifill_req_i.valid = 1'b0;
        repeat (3) tick();
        check($sformatf("%s_ack_cnt", tag), ack_cyc1.size(), 1);
        check($sformatf("%s_ack_lat", tag), qget(ack_cyc1, 0) - t0, 1);
        check($sformatf("%s_rsp_cnt", tag), rsp_cyc1.size(), 1);
        check($sformatf("%s_rsp_lat", tag), qget(rsp_cyc1, 0) - t0, v.exp_lat);
        check($sformatf("%s_data", tag), dget(rsp_dat1, 0), v.exp_data);
        check($sformatf("%s_beat", tag), qget(rsp_beat1, 0), 0);
        check($sformatf("%s_addr", tag), addr_seen1, v.exp_addr);
        check($sformatf("%s_len", tag), bus1.mem_req_len_o, 8'd1);
        check($sformatf("%s_req_cycles", tag), vcyc1, v.rdy + 1);
        check($sformatf("%s_addr_stable", tag), unstable1, 0);
        check($sformatf("%s_busy_end", tag), bus1.busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int k;

        vecs[0] = '{26'h001_2345, 2'd2, 64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002, 0, 0,
                    30'h0012_3450, 128'hBBBB_0000_0000_0002_AAAA_0000_0000_0001, 5};
        vecs[1] = '{26'h001_2345, 2'd2, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 5, 0,
                    30'h0012_3450, 128'h5555_6666_7777_8888_1111_2222_3333_4444, 10};
        vecs[2] = '{26'h3FF_FFFF, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2, 3,
                    30'h3FFF_FFF0, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 7};
        vecs[3] = '{26'h000_0000, 2'd0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1, 1,
                    30'h0000_0000, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF, 6};

        bus1.ifill_req_i = '0;
        bus4.ifill_req_i = '0;
        repeat (3) tick();

        // Reset state
        check("rst_ack", bus1.ifill_resp_o.ack, 1'b0);
        check("rst_valid", bus1.ifill_resp_o.valid, 1'b0);
        check("rst_data", bus1.ifill_resp_o.data, 128'h0);
        check("rst_beat", bus1.ifill_resp_o.beat, 2'd0);
        check("rst_mem_valid", bus1.mem_req_valid_o, 1'b0);
        check("rst_mem_addr", bus1.mem_req_addr_o, 30'h0);
        check("rst_busy", bus1.busy_o, 1'b0);
        check("rst_busy4", bus4.busy_o, 1'b0);
        rst = 1'b0;
        repeat (2) tick();

        // Table-driven single fills (incl. 5-cycle ready backpressure and held valid)
        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Valid held through the whole transfer: one ack per transfer, the second
        // accepted only after returning to IDLE, with a one-cycle bubble
        clear_mon1();
        rd1 = 0;
        wq1.push_back(64'hA0); wq1.push_back(64'hA1);
        wq1.push_back(64'hB0); wq1.push_back(64'hB1);
        tick();
        t0 = cyc;
        bus1.ifill_req_i = '{valid: 1'b1, way: 2'd1, paddr: 26'h0AB_CDEF};
        k = 0;
        while (ack_cyc1.size() < 2 && k < 40) begin tick(); k++; end
        bus1.ifill_req_i.valid = 1'b0;
        k = 0;
        while (rsp_cyc1.size() < 2 && k < 40) begin tick(); k++; end
        repeat (3) tick();
        check("b2b_ack_cnt", ack_cyc1.size(), 2);
        check("b2b_ack0_cyc", qget(ack_cyc1, 0) - t0, 1);
        check("b2b_ack1_cyc", qget(ack_cyc1, 1) - t0, 7);
        check("b2b_rsp_cnt", rsp_cyc1.size(), 2);
        check("b2b_rsp0_cyc", qget(rsp_cyc1, 0) - t0, 5);
        check("b2b_rsp1_cyc", qget(rsp_cyc1, 1) - t0, 11);
        check("b2b_rsp0_data", dget(rsp_dat1, 0), {64'hA1, 64'hA0});
        check("b2b_rsp1_data", dget(rsp_dat1, 1), {64'hB1, 64'hB0});
        check("b2b_overlap", ovl1, 0);

        // Reset after the first word of a transfer
        clear_mon1();
        rd1 = 0;
        wq1.push_back(64'hC0); wq1.push_back(64'hC1);
        tick();
        bus1.ifill_req_i = '{valid: 1'b1, way: 2'd2, paddr: 26'h123_4567};
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (ack_cyc1.size() > 0) bus1.ifill_req_i.valid = 1'b0;
        end
        check("mid_busy_before", bus1.busy_o, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_ack", bus1.ifill_resp_o.ack, 1'b0);
        check("mid_rst_valid", bus1.ifill_resp_o.valid, 1'b0);
        check("mid_rst_data", bus1.ifill_resp_o.data, 128'h0);
        check("mid_rst_beat", bus1.ifill_resp_o.beat, 2'd0);
        check("mid_rst_mem_valid", bus1.mem_req_valid_o, 1'b0);
        check("mid_rst_mem_addr", bus1.mem_req_addr_o, 30'h0);
        check("mid_rst_busy", bus1.busy_o, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
        check("mid_no_rsp", rsp_cyc1.size(), 0);
        check("mid_idle_busy", bus1.busy_o, 1'b0);
        run_vec(vecs[0], "post_rst");

        // Four-beat line with random word gaps
        rd4 = 0;
        for (int i = 0; i < 8; i++) wq4.push_back(64'(i));
        tick();
        bus4.ifill_req_i = '{valid: 1'b1, way: 2'd1, paddr: 26'h155_5555};
        k = 0;
        while (rsp_cyc4.size() < 4 && k < 200) begin
            tick();
            k++;
            if (ack_cyc4.size() > 0) bus4.ifill_req_i.valid = 1'b0;
        end
        bus4.ifill_req_i.valid = 1'b0;
        repeat (3) tick();
        check("mb_ack_cnt", ack_cyc4.size(), 1);
        check("mb_rsp_cnt", rsp_cyc4.size(), 4);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("mb_beat%0d_idx", b), qget(rsp_beat4, b), b);
            check($sformatf("mb_beat%0d_data", b), dget(rsp_dat4, b), {64'(2*b+1), 64'(2*b)});
        end
        check("mb_len", bus4.mem_req_len_o, 8'd7);
        check("mb_addr", addr_seen4, 30'h1555_5550);
        check("mb_overlap", ovl4, 0);
        check("mb_busy_end", bus4.busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sargantana_ifill_responder.md
Name: sargantana_ifill_responder

Overview:
- Memory-side end of the icache IFILL protocol.
- Accepts an ifill_req_o_t from the instruction cache and acknowledges it.
- Issues a line read on a 64-bit memory read port, then packs returned 64-bit words into 128-bit (WAY_WIDHT) beats.
- Returns each beat as ifill_resp_i_t with data and beat index. Sits between sargantana icache controller and the L2/memory bridge.

Parameters:
- LINE_BEATS, 1, 128-bit response beats per line (1..4; beat field is 2 bits)
- MEM_DATA_W, 64, memory read data width; WAY_WIDHT must be a multiple of it
- WORDS_PER_BEAT, WAY_WIDHT/MEM_DATA_W (2), derived localparam, not overridable

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- ifill_req_i  in  ifill_req_o_t (valid, way, paddr[PADDR_SIZE-1:0])  request from icache
- ifill_resp_o  out  ifill_resp_i_t (valid, ack, data[WAY_WIDHT-1:0], beat[1:0])  response to icache
- mem_req_valid_o  out  1  memory read request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  PADDR_SIZE+4  byte address = {paddr, 4'b0}
- mem_req_len_o  out  8  words requested minus one = LINE_BEATS*WORDS_PER_BEAT-1
- mem_resp_valid_i  in  1  read data word valid
- mem_resp_data_i  in  MEM_DATA_W  read data word, ascending address order
- busy_o  out  1  request in flight (state != IDLE)

Behaviour:
- Reset:
  - State IDLE.
  - All ifill_resp_o fields 0; mem_req_valid_o=0; mem_req_addr_o=0; busy_o=0.
  - Word and beat counters 0; packing buffer 0.
  - Reset mid-operation abandons the transfer; no response is produced.
- States: IDLE, MEM_REQ, COLLECT, SEND.
- IDLE:
  - On ifill_req_i.valid, latch paddr and way.
  - Drive ifill_resp_o.ack=1 for exactly the next cycle (registered), then go to MEM_REQ.
  - The icache drops valid after seeing ack. The responder ignores ifill_req_i.valid in every state other than IDLE, and for the one cycle following ack.
- MEM_REQ:
  - mem_req_valid_o=1 with the latched address and mem_req_len_o. The address is stable while valid.
  - Valid drops in the cycle after mem_req_ready_i is sampled high; then go to COLLECT.
- COLLECT:
  - Each mem_resp_valid_i cycle writes mem_resp_data_i into buffer slot word_cnt. Word 0 occupies bits [63:0], word 1 bits [127:64].
  - word_cnt increments, wrapping at WORDS_PER_BEAT.
  - On the word that completes a beat, go to SEND.
- SEND:
  - Single cycle: ifill_resp_o.valid=1, data=buffer, beat=beat_cnt. All other cycles have valid=0 and data held, not cleared.
  - If beat_cnt==LINE_BEATS-1: beat_cnt clears, go to IDLE.
  - Otherwise beat_cnt++ and return to COLLECT.
- Memory must not present a word during SEND. Data arriving in SEND is a protocol error, checked by assertion.
- mem_resp_valid_i in IDLE or MEM_REQ is dropped and flagged by assertion.
- Minimum latency, request valid to response valid with mem ready and data immediate: ack at +1, mem_req at +2, words at +3/+4, resp valid at +5.
- Back-to-back: a new request is accepted in IDLE the cycle after the final SEND.
- way is latched and held internally for waveform visibility only; it is not echoed (the icache owns the way).
- ack and valid are never high in the same cycle.

Decomposition:
- Add to sargantana_icache_pkg:
  - typedef enum logic[1:0] ifill_rsp_state_t {IFR_IDLE, IFR_MEM_REQ, IFR_COLLECT, IFR_SEND}
  - localparam IFILL_MEM_DATA_W = 64
  - localparam IFILL_WORDS_PER_BEAT = WAY_WIDHT/IFILL_MEM_DATA_W
- One natural sub-module: sargantana_ifill_packer.
  - Word counter plus WAY_WIDHT buffer.
  - Inputs: word valid/data and clear.
  - Outputs: buffer and beat_done.
  - Instantiated once.

Test Plan:
- Single fill:
  - Stimulus: paddr=26'h01_2345, way=2, memory ready and returning words 64'hAAAA_0000_0000_0001 then 64'hBBBB_0000_0000_0002.
  - Required: ack one cycle; mem_req_addr_o=30'h012_3450; len=1; resp valid once with data=128'hBBBB_0000_0000_0002_AAAA_0000_0000_0001, beat=0.
- Memory backpressure: mem_req_ready_i low for 5 cycles -> mem_req_valid_o held 5 cycles with address stable; response timing shifts by exactly 5.
- Multi-beat: LINE_BEATS=4, 8 words 64'h0..64'h7 with random 0-3 cycle gaps -> four resp valid pulses, beat=0,1,2,3, beat k data={2k+1, 2k}; then IDLE and busy_o=0.
- Held request / ignore while busy: icache holds valid 3 cycles after ack and a second request arrives during COLLECT -> exactly one ack and one transfer; second request accepted only after return to IDLE.
- Reset mid-transfer: assert rst_i after the first word in COLLECT -> all outputs 0 immediately (async); no resp valid; next request after reset completes normally.
- Back-to-back: new request valid in the cycle after the final SEND -> ack the following cycle with no idle bubble beyond one cycle.
